wram_mem_bridge: RTL and testbench

Converts the strobe-style work-RAM port (17-bit address, RD/WE/CE strobes, 8-bit data) produced by the WRAM controller into a single-request/acknowledge transaction stream for the shared SDRAM arbiter. It sits directly downstream of the WRAM controller. It detects strobe edges, launches one memory transaction per strobe, and queues one further transaction while the current one is in flight. Read data is held on `RAM_Q` until the next read completes.

---
 rtl/wram_mem_bridge.sv | 171 +++++++++++++++++
 tb/tb_wram_mem_bridge.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wram_mem_bridge.sv
// Bridges the strobe-style WRAM port to a single req/ack memory transaction stream.
// One transaction can be in flight, and one more can wait in a depth-1 pending slot.
module wram_mem_bridge #(
  parameter int                MEM_AW = 22,
  parameter logic [MEM_AW-1:0] BASE   = 22'h3E0000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [16:0]       RAM_A,
  input  logic [7:0]        RAM_D,
  input  logic              RAM_CE_N,
  input  logic              RAM_RD_N,
  input  logic              RAM_WE_N,
  output logic [7:0]        RAM_Q,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic              mem_ack,
  input  logic [7:0]        mem_dout,
  output logic              busy,
  output logic              ovf
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_e;

  typedef struct packed {
    logic        we;
    logic [16:0] a;
    logic [7:0]  d;
  } op_t;

  // Handshake: mem_req and its payload are held stable until the cycle mem_ack
  // is high; that cycle completes the transaction, and a queued op may launch next.
  state_e            state_q, state_d;
  logic              rd_n_q, we_n_q;
  logic [16:0]       wa_q;
  logic [7:0]        wd_q;
  logic              sh_v_q;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [7:0]        din_q, din_d;
  logic              pend_v_q, pend_v_d;
  op_t               pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        ram_q_q, ram_q_d;

  logic              rd_start, wr_track, wr_commit;
  op_t               wr_op, rd_op;
  op_t               cand [3];
  logic [2:0]        cand_v;
  op_t               first, second;
  logic              first_v, second_v, drop;

  assign rd_start  = ~RAM_RD_N & rd_n_q & ~RAM_CE_N;
  assign wr_track  = ~RAM_WE_N & ~RAM_CE_N;
  // Commit is not gated by CE, so a write whose CE rises before WE still lands.
  assign wr_commit = RAM_WE_N & ~we_n_q & sh_v_q;

  always_comb begin
    wr_op   = '{we: 1'b1, a: wa_q, d: wd_q};
    rd_op   = '{we: 1'b0, a: RAM_A, d: 8'h00};
    // Candidates in priority order: the queued op, then the write, then the read.
    cand[0] = pend_q;
    cand[1] = wr_commit ? wr_op : rd_op;
    cand[2] = rd_op;
    cand_v  = {wr_commit & rd_start, wr_commit | rd_start, pend_v_q};

    first    = '0;
    second   = '0;
    first_v  = 1'b0;
    second_v = 1'b0;
    drop     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (cand_v[i]) begin
        if (!first_v) begin
          first_v = 1'b1;
          first   = cand[i];
        end else if (!second_v) begin
          second_v = 1'b1;
          second   = cand[i];
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    din_d    = din_q;
    pend_v_d = pend_v_q;
    pend_d   = pend_q;
    ovf_d    = ovf_q;
    ram_q_d  = ram_q_q;

    if (state_q == S_RD && mem_ack) ram_q_d = mem_dout;

    if (state_q == S_IDLE || mem_ack) begin
      pend_v_d = second_v;
      pend_d   = second;
      if (drop) ovf_d = 1'b1;
      if (first_v) begin
        state_d = first.we ? S_WR : S_RD;
        req_d   = 1'b1;
        we_d    = first.we;
        addr_d  = {BASE[MEM_AW-1:17], first.a};
        din_d   = first.d;
      end else begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    end else begin
      // Busy without ack: the slot keeps (or takes) the oldest op, the rest is lost.
      pend_v_d = first_v;
      pend_d   = first;
      if (second_v) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      rd_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      wa_q     <= '0;
      wd_q     <= '0;
      sh_v_q   <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      pend_v_q <= 1'b0;
      pend_q   <= '0;
      ovf_q    <= 1'b0;
      ram_q_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      rd_n_q   <= RAM_RD_N;
      we_n_q   <= RAM_WE_N;
      if (wr_track) begin
        wa_q   <= RAM_A;
        wd_q   <= RAM_D;
        sh_v_q <= 1'b1;
      end else if (wr_commit) begin
        sh_v_q <= 1'b0;
      end
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      pend_v_q <= pend_v_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      ram_q_q  <= ram_q_d;
    end
  end

  assign RAM_Q    = ram_q_q;
  assign mem_req  = req_q;
  assign mem_we   = we_q;
  assign mem_addr = addr_q;
  assign mem_din  = din_q;
  assign busy     = (state_q != S_IDLE) | pend_v_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_wram_mem_bridge.sv
// Directed bench for wram_mem_bridge: hand-computed request payloads and timing.
module tb_wram_mem_bridge;
  localparam int W = 31;

  logic        clk = 1'b0;
  logic        RST;
  logic [16:0] RAM_A;
  logic [7:0]  RAM_D;
  logic        RAM_CE_N, RAM_RD_N, RAM_WE_N;
  logic [7:0]  RAM_Q;
  logic        mem_req, mem_we;
  logic [21:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_ack;
  logic [7:0]  mem_dout;
  logic        busy, ovf;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  // clock / reset
  always #5 clk = ~clk;

  wram_mem_bridge #(.MEM_AW(22), .BASE(22'h3E0000)) dut (
    .CLK(clk), .RST(RST), .RAM_A(RAM_A), .RAM_D(RAM_D),
    .RAM_CE_N(RAM_CE_N), .RAM_RD_N(RAM_RD_N), .RAM_WE_N(RAM_WE_N),
    .RAM_Q(RAM_Q), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_ack(mem_ack), .mem_dout(mem_dout),
    .busy(busy), .ovf(ovf)
  );

  // Every completed transaction (req high in an ack cycle) is logged; read din is ignored.
  always @(posedge clk) begin
    if (!RST && mem_req && mem_ack)
      got_q.push_back({mem_we, mem_addr, (mem_we ? mem_din : 8'h00)});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    RAM_A    = '0;
    RAM_D    = '0;
    RAM_CE_N = 1'b1;
    RAM_RD_N = 1'b1;
    RAM_WE_N = 1'b1;
    mem_ack  = 1'b0;
    mem_dout = '0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic ack_pulse(input logic [7:0] d);
    mem_ack  = 1'b1;
    mem_dout = d;
    tick();
    mem_ack  = 1'b0;
    mem_dout = '0;
  endtask

  // scoreboard: transactions seen must match the expected queue in order
  task automatic drain(input string tag);
    logic [W-1:0] e, g;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check({tag, "_txn"}, g, e);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    reset_dut();
    check("rst_ramq", RAM_Q, 8'h00);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_din", mem_din, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);

    // single read, strobe held 6 cycles
    RAM_A = 17'h1ABCD; RAM_CE_N = 0; RAM_RD_N = 0;
    tick();
    check("rd_req", mem_req, 1);
    check("rd_addr", mem_addr, 22'h3FABCD);
    check("rd_we", mem_we, 0);
    check("rd_busy", busy, 1);
    exp_q.push_back({1'b0, 22'h3FABCD, 8'h00});
    tick();
    tick();
    check("rd_req_hold", mem_req, 1);
    check("rd_addr_hold", mem_addr, 22'h3FABCD);
    ack_pulse(8'h5A);
    check("rd_ramq", RAM_Q, 8'h5A);
    check("rd_req_drop", mem_req, 0);
    tick();
    tick();
    check("rd_single", mem_req, 0);
    check("rd_idle", busy, 0);
    RAM_RD_N = 1; RAM_CE_N = 1;
    tick();
    drain("t1");

    // single write, data changes in the last strobe cycle
    RAM_A = 17'h00010; RAM_D = 8'h11; RAM_CE_N = 0; RAM_WE_N = 0;
    tick(); tick(); tick();
    RAM_D = 8'h22;
    tick();
    check("wr_no_early_req", mem_req, 0);
    RAM_WE_N = 1;
    tick();
    check("wr_req", mem_req, 1);
    check("wr_we", mem_we, 1);
    check("wr_addr", mem_addr, 22'h3E0010);
    check("wr_din", mem_din, 8'h22);
    exp_q.push_back({1'b1, 22'h3E0010, 8'h22});
    RAM_CE_N = 1;
    tick();
    check("wr_din_hold", mem_din, 8'h22);
    ack_pulse(8'h00);
    check("wr_done", mem_req, 0);
    check("wr_ramq_kept", RAM_Q, 8'h5A);
    drain("t2");

    // queued: write commits while a read is outstanding
    RAM_A = 17'h0; RAM_CE_N = 0; RAM_RD_N = 0;
    tick();
    check("q_rd_addr", mem_addr, 22'h3E0000);
    exp_q.push_back({1'b0, 22'h3E0000, 8'h00});
    RAM_RD_N = 1; RAM_WE_N = 0; RAM_A = 17'h1; RAM_D = 8'h33;
    tick();
    RAM_WE_N = 1;
    tick();
    check("q_busy", busy, 1);
    check("q_still_rd", mem_we, 0);
    RAM_CE_N = 1;
    ack_pulse(8'h77);
    exp_q.push_back({1'b1, 22'h3E0001, 8'h33});
    check("q_req_cont", mem_req, 1);
    check("q_wr_we", mem_we, 1);
    check("q_wr_addr", mem_addr, 22'h3E0001);
    check("q_wr_din", mem_din, 8'h33);
    check("q_ramq", RAM_Q, 8'h77);
    tick();
    check("q_busy_mid", busy, 1);
    ack_pulse(8'h00);
    check("q_busy_end", busy, 0);
    check("q_req_end", mem_req, 0);
    drain("t3");

    // overflow: three reads while the first is unacknowledged
    check("ov_pre", ovf, 0);
    RAM_CE_N = 0;
    RAM_A = 17'h2; RAM_RD_N = 0; tick();
    RAM_RD_N = 1; tick();
    RAM_A = 17'h3; RAM_RD_N = 0; tick();
    check("ov_no_flag", ovf, 0);
    RAM_RD_N = 1; tick();
    RAM_A = 17'h4; RAM_RD_N = 0; tick();
    check("ov_flag", ovf, 1);
    check("ov_addr_stable", mem_addr, 22'h3E0002);
    RAM_RD_N = 1; RAM_CE_N = 1;
    exp_q.push_back({1'b0, 22'h3E0002, 8'h00});
    exp_q.push_back({1'b0, 22'h3E0003, 8'h00});
    ack_pulse(8'hA1);
    check("ov_second_addr", mem_addr, 22'h3E0003);
    tick();
    ack_pulse(8'hB2);
    tick(); tick();
    check("ov_sticky", ovf, 1);
    check("ov_idle", busy, 0);
    check("ov_ramq", RAM_Q, 8'hB2);
    drain("t4");

    // simultaneous write commit + read start from IDLE
    reset_dut();
    check("sim_ovf_clr", ovf, 0);
    RAM_CE_N = 0; RAM_WE_N = 0; RAM_A = 17'h5; RAM_D = 8'h44;
    tick();
    RAM_WE_N = 1; RAM_RD_N = 0; RAM_A = 17'h6;
    tick();
    check("sim_first_we", mem_we, 1);
    check("sim_first_addr", mem_addr, 22'h3E0005);
    check("sim_first_din", mem_din, 8'h44);
    RAM_RD_N = 1; RAM_CE_N = 1;
    exp_q.push_back({1'b1, 22'h3E0005, 8'h44});
    exp_q.push_back({1'b0, 22'h3E0006, 8'h00});
    ack_pulse(8'h00);
    check("sim_second_we", mem_we, 0);
    check("sim_second_addr", mem_addr, 22'h3E0006);
    ack_pulse(8'hC3);
    check("sim_ramq", RAM_Q, 8'hC3);
    check("sim_ovf", ovf, 0);
    check("sim_idle", busy, 0);
    drain("t5");

    // reset during an outstanding read, then a late ack
    RAM_A = 17'h7; RAM_CE_N = 0; RAM_RD_N = 0;
    tick();
    check("rr_req", mem_req, 1);
    RST = 1; RAM_RD_N = 1; RAM_CE_N = 1;
    tick();
    RST = 0;
    check("rr_req", mem_req, 0);
    check("rr_addr", mem_addr, 0);
    check("rr_busy", busy, 0);
    check("rr_ovf", ovf, 0);
    ack_pulse(8'h99);
    check("rr_ramq", RAM_Q, 8'h00);
    check("rr_req_after", mem_req, 0);
    check("rr_busy_after", busy, 0);
    drain("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
